dmem_port_arbiter: RTL and testbench

//  Shares the single processor-to-memory port between three requesters: store-queue drain (ST),
//  LSQ load miss (LD) and I-fetch (IF). Issues at most one bus command per cycle.

---
 rtl/dmem_port_arbiter_pkg.sv | 34 +++
 rtl/dmem_port_arbiter_chan.sv | 82 ++++++++
 rtl/dmem_port_arbiter.sv | 148 ++++++++++++++
 tb/tb_dmem_port_arbiter.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/dmem_port_arbiter_pkg.sv
// Purpose: shared types and constants for the data-memory port arbiter.
//   bus_cmd_t    - processor-to-memory command encoding
//   chan_state_t - per-channel (LD / IF) outstanding-request state
//   win_t        - which requester owns the bus in the current cycle
// Optional feature macro used by the arbiter: MEMARB_AGE_EN (IF starvation aging).
package dmem_port_arbiter_pkg;

  localparam int TAG_W        = 4;   // memory tag width; tag 0 means "rejected / none"
  localparam int XLEN         = 32;  // address / store-data width
  localparam int STARVE_LIMIT = 8;   // denied cycles before IF is promoted (aging build only)

  // Fetches always move a full 64-bit line word.
  localparam logic [2:0] IF_SIZE = 3'd3;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  typedef enum logic [1:0] {
    CH_IDLE = 2'h0,
    CH_WAIT = 2'h1,
    CH_DROP = 2'h2
  } chan_state_t;

  typedef enum logic [1:0] {
    WIN_NONE = 2'h0,
    WIN_ST   = 2'h1,
    WIN_LD   = 2'h2,
    WIN_IF   = 2'h3
  } win_t;

endpackage

// File: rtl/dmem_port_arbiter_chan.sv
// Purpose: one tagged memory channel (LD or IF). Captures the accept tag when its
//   command is taken by memory, waits for the matching return tag and routes the data.
//   A rollback kills the outstanding request: the return is still consumed (so the
//   tag is retired) but not reported.
// Ports:
//   clock, reset      - system clock, synchronous active-low reset
//   rollback          - squash; tie 0 for channels that must not be killed
//   grant_fire        - this channel won the bus and memory accepted it this cycle
//   resp_tag          - accept tag from memory (valid with grant_fire)
//   ret_tag, ret_data - returning tag / data from memory
//   idle              - channel can take a new request this cycle
//   gnt               - pulse: request accepted (hidden if squashed in the same cycle)
//   valid, data       - pulse + data of a live return (data is 0 otherwise)
//   state_dbg         - current channel state
// Handshake: requester holds its request until gnt; gnt and valid are single-cycle
//   pulses decoded combinationally from this cycle's memory inputs.
module dmem_port_arbiter_chan
  import dmem_port_arbiter_pkg::*;
#(
  parameter int TW = TAG_W
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          rollback,
  input  logic          grant_fire,
  input  logic [TW-1:0] resp_tag,
  input  logic [TW-1:0] ret_tag,
  input  logic [63:0]   ret_data,
  output logic          idle,
  output logic          gnt,
  output logic          valid,
  output logic [63:0]   data,
  output chan_state_t   state_dbg
);

  chan_state_t   state_q, state_d;
  logic [TW-1:0] tag_q, tag_d;
  logic          match;

  // Tag 0 never names an outstanding request, so it can never match.
  assign match = (state_q != CH_IDLE) && (ret_tag != '0) && (ret_tag == tag_q);

  always_comb begin
    state_d = state_q;
    tag_d   = tag_q;
    case (state_q)
      CH_IDLE: begin
        if (grant_fire) begin
          tag_d   = resp_tag;
          // Squash in the accept cycle: memory still owes us a response, so
          // drain it silently instead of returning to IDLE.
          state_d = rollback ? CH_DROP : CH_WAIT;
        end
      end
      CH_WAIT: begin
        if (match)         state_d = CH_IDLE;
        else if (rollback) state_d = CH_DROP;
      end
      CH_DROP: begin
        if (match) state_d = CH_IDLE;
      end
      default: state_d = CH_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= CH_IDLE;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      tag_q   <= tag_d;
    end
  end

  assign idle      = (state_q == CH_IDLE);
  assign gnt       = reset && grant_fire && !rollback;
  assign valid     = reset && match && (state_q == CH_WAIT) && !rollback;
  assign data      = valid ? ret_data : 64'h0;
  assign state_dbg = state_q;

endmodule

// File: rtl/dmem_port_arbiter.sv
// Purpose: shares the single processor-to-memory port between store-queue drain (ST),
//   LSQ load miss (LD) and instruction fetch (IF). At most one command per cycle; the
//   winner drives the bus combinationally and is accepted iff mem2proc_response != 0.
// Priority: ST > LD > IF. With MEMARB_AGE_EN defined, an IF request denied for
//   STARVE_LIMIT consecutive cycles is promoted above ST for one cycle.
// Ports:
//   clock, reset (sync, active-low), rollback (kills in-flight LD only)
//   st_req/st_addr/st_data/st_size -> st_done (pulse, store accepted)
//   ld_req/ld_addr/ld_size         -> ld_gnt, ld_valid, ld_data
//   if_req/if_addr                 -> if_gnt, if_valid, if_data
//   proc2mem_command/addr/data/size, mem2proc_response/data/tag
//   ld_state_dbg, if_state_dbg     - channel FSM states
// Handshake: each requester holds *_req until its grant pulse; a rejected command
//   (response 0) produces no grant and the requester simply retries.
module dmem_port_arbiter
  import dmem_port_arbiter_pkg::*;
(
  input  logic             clock,
  input  logic             reset,
  input  logic             rollback,
  input  logic             st_req,
  input  logic [XLEN-1:0]  st_addr,
  input  logic [XLEN-1:0]  st_data,
  input  logic [2:0]       st_size,
  output logic             st_done,
  input  logic             ld_req,
  input  logic [XLEN-1:0]  ld_addr,
  input  logic [2:0]       ld_size,
  output logic             ld_gnt,
  output logic             ld_valid,
  output logic [63:0]      ld_data,
  input  logic             if_req,
  input  logic [XLEN-1:0]  if_addr,
  output logic             if_gnt,
  output logic             if_valid,
  output logic [63:0]      if_data,
  output bus_cmd_t         proc2mem_command,
  output logic [XLEN-1:0]  proc2mem_addr,
  output logic [63:0]      proc2mem_data,
  output logic [2:0]       proc2mem_size,
  input  logic [TAG_W-1:0] mem2proc_response,
  input  logic [63:0]      mem2proc_data,
  input  logic [TAG_W-1:0] mem2proc_tag,
  output chan_state_t      ld_state_dbg,
  output chan_state_t      if_state_dbg
);

  logic ld_idle, if_idle;
  logic ld_elig, if_elig;
  logic accept;
  logic promote;
  win_t win;

  assign accept  = (mem2proc_response != '0);
  assign ld_elig = ld_req && ld_idle;
  assign if_elig = if_req && if_idle;

`ifdef MEMARB_AGE_EN
  logic [7:0] starve_q, starve_d;

  assign promote = if_elig && (starve_q == 8'(STARVE_LIMIT));

  // Counts consecutive cycles IF wanted the bus and did not get it.
  always_comb begin
    starve_d = starve_q;
    if (!if_elig || if_gnt)    starve_d = 8'h0;
    else if (starve_q != 8'hFF) starve_d = starve_q + 8'h1;
  end

  always_ff @(posedge clock) begin
    if (!reset) starve_q <= 8'h0;
    else        starve_q <= starve_d;
  end
`else
  assign promote = 1'b0;
`endif

  always_comb begin
    win = WIN_NONE;
    if (reset) begin
      if (promote)      win = WIN_IF;
      else if (st_req)  win = WIN_ST;
      else if (ld_elig) win = WIN_LD;
      else if (if_elig) win = WIN_IF;
    end
  end

  always_comb begin
    proc2mem_command = BUS_NONE;
    proc2mem_addr    = '0;
    proc2mem_data    = 64'h0;
    proc2mem_size    = 3'd0;
    case (win)
      WIN_ST: begin
        proc2mem_command = BUS_STORE;
        proc2mem_addr    = st_addr;
        proc2mem_data    = 64'(st_data);
        proc2mem_size    = st_size;
      end
      WIN_LD: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = ld_addr;
        proc2mem_size    = ld_size;
      end
      WIN_IF: begin
        proc2mem_command = BUS_LOAD;
        proc2mem_addr    = if_addr;
        proc2mem_size    = IF_SIZE;
      end
      default: ;
    endcase
  end

  // Stores are retired state: no tag tracking and immune to rollback.
  assign st_done = (win == WIN_ST) && accept;

  dmem_port_arbiter_chan #(.TW(TAG_W)) u_ld_chan (
    .clock      (clock),
    .reset      (reset),
    .rollback   (rollback),
    .grant_fire ((win == WIN_LD) && accept),
    .resp_tag   (mem2proc_response),
    .ret_tag    (mem2proc_tag),
    .ret_data   (mem2proc_data),
    .idle       (ld_idle),
    .gnt        (ld_gnt),
    .valid      (ld_valid),
    .data       (ld_data),
    .state_dbg  (ld_state_dbg)
  );

  // Fetch is never squashed by a data-side rollback.
  dmem_port_arbiter_chan #(.TW(TAG_W)) u_if_chan (
    .clock      (clock),
    .reset      (reset),
    .rollback   (1'b0),
    .grant_fire ((win == WIN_IF) && accept),
    .resp_tag   (mem2proc_response),
    .ret_tag    (mem2proc_tag),
    .ret_data   (mem2proc_data),
    .idle       (if_idle),
    .gnt        (if_gnt),
    .valid      (if_valid),
    .data       (if_data),
    .state_dbg  (if_state_dbg)
  );

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: a sequential table of per-cycle vectors plus
// hand-written sequences for reset-in-flight and IF starvation.
module tb_dmem_port_arbiter;
  import dmem_port_arbiter_pkg::*;

  localparam bit AGE =
`ifdef MEMARB_AGE_EN
    1'b1;
`else
    1'b0;
`endif

  localparam logic [31:0] ST_A = 32'h0000_1000;
  localparam logic [31:0] LD_A = 32'h0000_2000;
  localparam logic [31:0] IF_A = 32'h0000_3000;
  localparam logic [31:0] ST_D = 32'hCAFE_F00D;
  localparam int OW = 5 + 2 + 32 + 64 + 3 + 64 + 64;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  // ---------------- DUT ----------------
  logic             rollback = 1'b0;
  logic             st_req = 1'b0, ld_req = 1'b0, if_req = 1'b0;
  logic [31:0]      st_addr = ST_A, st_data = ST_D, ld_addr = LD_A, if_addr = IF_A;
  logic [2:0]       st_size = 3'd2, ld_size = 3'd1;
  logic [TAG_W-1:0] mem2proc_response = '0, mem2proc_tag = '0;
  logic [63:0]      mem2proc_data = 64'h0;
  logic             st_done, ld_gnt, ld_valid, if_gnt, if_valid;
  logic [63:0]      ld_data, if_data, proc2mem_data;
  logic [31:0]      proc2mem_addr;
  logic [2:0]       proc2mem_size;
  bus_cmd_t         proc2mem_command;
  chan_state_t      ld_state_dbg, if_state_dbg;

  dmem_port_arbiter dut (
    .clock(clock), .reset(reset), .rollback(rollback),
    .st_req(st_req), .st_addr(st_addr), .st_data(st_data), .st_size(st_size), .st_done(st_done),
    .ld_req(ld_req), .ld_addr(ld_addr), .ld_size(ld_size),
    .ld_gnt(ld_gnt), .ld_valid(ld_valid), .ld_data(ld_data),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_data(if_data),
    .proc2mem_command(proc2mem_command), .proc2mem_addr(proc2mem_addr),
    .proc2mem_data(proc2mem_data), .proc2mem_size(proc2mem_size),
    .mem2proc_response(mem2proc_response), .mem2proc_data(mem2proc_data),
    .mem2proc_tag(mem2proc_tag),
    .ld_state_dbg(ld_state_dbg), .if_state_dbg(if_state_dbg)
  );

  // ---------------- vectors ----------------
  typedef struct {
    string            name;
    logic             rst;      // 1 = hold reset this cycle
    logic [3:0]       reqs;     // {st, ld, if, rollback}
    logic [TAG_W-1:0] resp;
    logic [TAG_W-1:0] tag;
    logic [63:0]      mdata;
    logic [4:0]       fl;       // {st_done, ld_gnt, ld_valid, if_gnt, if_valid}
    bus_cmd_t         cmd;
    logic [31:0]      addr;
    logic [63:0]      ldd;
    logic [63:0]      ifd;
  } vec_t;

  function automatic vec_t mk(string n, logic [3:0] rq, logic [TAG_W-1:0] rs,
                              logic [TAG_W-1:0] tg, logic [63:0] md, logic [4:0] fl,
                              bus_cmd_t c, logic [31:0] ad, logic [63:0] ldd, logic [63:0] ifd);
    vec_t v;
    v.name = n; v.rst = 1'b0; v.reqs = rq; v.resp = rs; v.tag = tg; v.mdata = md;
    v.fl = fl; v.cmd = c; v.addr = ad; v.ldd = ldd; v.ifd = ifd;
    return v;
  endfunction

  function automatic logic [OW-1:0] pack(logic [4:0] fl, logic [1:0] c, logic [31:0] ad,
                                         logic [63:0] pd, logic [2:0] sz,
                                         logic [63:0] ldd, logic [63:0] ifd);
    return {fl, c, ad, pd, sz, ldd, ifd};
  endfunction

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  int checks = 0;
  int failures = 0;

  task automatic run(input vec_t v);
    logic [OW-1:0] a, e;
    logic [63:0]   epd;
    logic [2:0]    esz;
    @(negedge clock);
    reset             = !v.rst;
    st_req            = v.reqs[3];
    ld_req            = v.reqs[2];
    if_req            = v.reqs[1];
    rollback          = v.reqs[0];
    mem2proc_response = v.resp;
    mem2proc_tag      = v.tag;
    mem2proc_data     = v.mdata;
    epd = (v.cmd == BUS_STORE) ? {32'h0, ST_D} : 64'h0;
    esz = (v.addr == ST_A) ? 3'd2 : (v.addr == LD_A) ? 3'd1 : (v.addr == IF_A) ? 3'd3 : 3'd0;
    exp_q.push_back(pack(v.fl, v.cmd, v.addr, epd, esz, v.ldd, v.ifd));
    #2;
    a = pack({st_done, ld_gnt, ld_valid, if_gnt, if_valid}, proc2mem_command, proc2mem_addr,
             proc2mem_data, proc2mem_size, ld_data, if_data);
    e = exp_q.pop_front();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %h expected %h", v.name, a, e);
    end
  endtask

  task automatic chk_state(input string n, input chan_state_t eld, input chan_state_t eif);
    @(posedge clock);
    #1;
    checks++;
    if (ld_state_dbg !== eld || if_state_dbg !== eif) begin
      failures++;
      $display("FAIL %s: got ld=%0d if=%0d expected ld=%0d if=%0d",
               n, ld_state_dbg, if_state_dbg, eld, eif);
    end
  endtask

  // ---------------- test ----------------
  initial begin
    vec_t tbl[$];
    vec_t v;

    // Reset state: requests and responses present, everything must stay quiet.
    v = mk("reset", 4'b1110, 4'd3, 4'd3, 64'hFFFF, 5'b00000, BUS_NONE, 32'h0, 64'h0, 64'h0);
    v.rst = 1'b1;
    run(v);
    run(v);
    chk_state("reset_state", CH_IDLE, CH_IDLE);

    tbl.push_back(mk("all_req",       4'b1110, 3, 0, 64'h0,    5'b10000, BUS_STORE, ST_A, 0, 0));
    tbl.push_back(mk("ld_acc5",       4'b0100, 5, 0, 64'h0,    5'b01000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("idle1",         4'b0000, 0, 0, 64'h0,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("idle2",         4'b0000, 0, 0, 64'h0,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("idle3",         4'b0000, 0, 0, 64'h0,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("ld_ret5",       4'b0000, 0, 5, 64'hDEAD, 5'b00100, BUS_NONE,  0, 64'hDEAD, 0));
    tbl.push_back(mk("ld_rej1",       4'b0100, 0, 0, 64'h0,    5'b00000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_rej2",       4'b0100, 0, 0, 64'h0,    5'b00000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_rej3",       4'b0100, 0, 0, 64'h0,    5'b00000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_acc2",       4'b0100, 2, 0, 64'h0,    5'b01000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_ret2",       4'b0000, 0, 2, 64'h1111, 5'b00100, BUS_NONE,  0, 64'h1111, 0));
    tbl.push_back(mk("ld_acc6",       4'b0100, 6, 0, 64'h0,    5'b01000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("rb_wait",       4'b0001, 0, 0, 64'h0,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("drop_ret6",     4'b0000, 0, 6, 64'hBEEF, 5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("ld_after_drop", 4'b0100, 7, 0, 64'h0,    5'b01000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_ret7",       4'b0000, 0, 7, 64'h77,   5'b00100, BUS_NONE,  0, 64'h77, 0));
    tbl.push_back(mk("if_acc1",       4'b0010, 1, 0, 64'h0,    5'b00010, BUS_LOAD,  IF_A, 0, 0));
    tbl.push_back(mk("ld_acc2b",      4'b0100, 2, 0, 64'h0,    5'b01000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_ret2b",      4'b0000, 0, 2, 64'hA,    5'b00100, BUS_NONE,  0, 64'hA, 0));
    tbl.push_back(mk("if_ret1",       4'b0000, 0, 1, 64'hB,    5'b00001, BUS_NONE,  0, 0, 64'hB));
    tbl.push_back(mk("ld_over_if",    4'b0110, 4, 0, 64'h0,    5'b01000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_ret_if_rej", 4'b0010, 0, 4, 64'hC,    5'b00100, BUS_LOAD,  IF_A, 64'hC, 0));
    tbl.push_back(mk("if_acc9",       4'b0010, 9, 0, 64'h0,    5'b00010, BUS_LOAD,  IF_A, 0, 0));
    tbl.push_back(mk("tag_nomatch",   4'b0000, 0, 8, 64'h5,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("tag_zero",      4'b0000, 0, 0, 64'h6,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("if_ret9",       4'b0000, 0, 9, 64'h6,    5'b00001, BUS_NONE,  0, 0, 64'h6));
    tbl.push_back(mk("rb_at_acc",     4'b0101, 3, 0, 64'h0,    5'b00000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_in_drop",    4'b0100, 5, 0, 64'h0,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("drop_ret3",     4'b0000, 0, 3, 64'h1,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("ld_acc5b",      4'b0100, 5, 0, 64'h0,    5'b01000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("rb_at_ret",     4'b0001, 0, 5, 64'h2,    5'b00000, BUS_NONE,  0,    0, 0));
    tbl.push_back(mk("ld_acc1",       4'b0100, 1, 0, 64'h0,    5'b01000, BUS_LOAD,  LD_A, 0, 0));
    tbl.push_back(mk("ld_ret1",       4'b0000, 0, 1, 64'h2,    5'b00100, BUS_NONE,  0, 64'h2, 0));
    tbl.push_back(mk("st_rb",         4'b1001, 2, 0, 64'h0,    5'b10000, BUS_STORE, ST_A, 0, 0));
    tbl.push_back(mk("if_rb_acc",     4'b0011, 2, 0, 64'h0,    5'b00010, BUS_LOAD,  IF_A, 0, 0));
    tbl.push_back(mk("if_rb_ret",     4'b0001, 0, 2, 64'h3,    5'b00001, BUS_NONE,  0, 0, 64'h3));
    tbl.push_back(mk("if_acc4",       4'b0010, 4, 0, 64'h0,    5'b00010, BUS_LOAD,  IF_A, 0, 0));
    tbl.push_back(mk("if_ret_same",   4'b0010, 5, 4, 64'h9,    5'b00001, BUS_NONE,  0, 0, 64'h9));
    tbl.push_back(mk("if_acc5",       4'b0010, 5, 0, 64'h0,    5'b00010, BUS_LOAD,  IF_A, 0, 0));

    foreach (tbl[i]) run(tbl[i]);

    // Reset while both channels are waiting.
    run(mk("ld_acc6_pre", 4'b0100, 6, 0, 64'h0, 5'b01000, BUS_LOAD, LD_A, 0, 0));
    chk_state("both_wait", CH_WAIT, CH_WAIT);
    v = mk("mid_reset", 4'b1110, 3, 5, 64'h1234, 5'b00000, BUS_NONE, 0, 0, 0);
    v.rst = 1'b1;
    run(v);
    chk_state("after_reset", CH_IDLE, CH_IDLE);
    run(mk("post_rst_tag6", 4'b0000, 0, 6, 64'h1, 5'b00000, BUS_NONE, 0, 0, 0));
    run(mk("post_rst_tag5", 4'b0000, 0, 5, 64'h2, 5'b00000, BUS_NONE, 0, 0, 0));

    // ST and IF held with memory always accepting.
    for (int i = 0; i < 10; i++) begin
      if (AGE && i == 8)
        run(mk($sformatf("starve_%0d", i), 4'b1010, 1, 0, 64'h0, 5'b00010, BUS_LOAD, IF_A, 0, 0));
      else
        run(mk($sformatf("starve_%0d", i), 4'b1010, 1, 0, 64'h0, 5'b10000, BUS_STORE, ST_A, 0, 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
